// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 keyboard receiver: prefix bytes, frame states and
// the bit layout of the ps2_key event word.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_PAUSE  = 8'hE1;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_BAT    = 8'hAA;
    localparam logic [7:0] PS2_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_RESEND = 8'hFE;

    typedef logic [1:0] frame_state_t;
    localparam frame_state_t StIdle   = 2'd0;
    localparam frame_state_t StData   = 2'd1;
    localparam frame_state_t StParity = 2'd2;
    localparam frame_state_t StStop   = 2'd3;

    localparam int unsigned KEY_W        = 11;
    localparam int unsigned KEY_TOGGLE   = 10;
    localparam int unsigned KEY_PRESSED  = 9;
    localparam int unsigned KEY_EXT      = 8;
    localparam int unsigned KEY_CODE_MSB = 7;

    // Controller replies and error codes that never map to a key.
    function automatic logic is_filler_code(input logic [7:0] b);
        return (b == PS2_ACK) || (b == PS2_BAT) || (b == PS2_ECHO) ||
               (b == PS2_RESEND) || (b == 8'h00) || (b == 8'hFF);
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: pin synchronizers, clock glitch filter, 11-bit frame FSM
// and inter-edge timeout. Emits one byte per good frame or a one-cycle error.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 716
) (
    input  logic       clk_3m58,
    input  logic       reset,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o,
    output logic       busy_o
);

    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    clk_sync_q, data_sync_q;
    logic          filt_q, filt_d, filt_prev_q, fall_q;
    logic [FW-1:0] fcnt_q, fcnt_d;
    frame_state_t  state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic          byte_valid_q, byte_valid_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          err, timeout, data_bit;

    assign data_bit = data_sync_q[1];

    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (clk_sync_q[1] != filt_q) begin
            if (fcnt_q == FW'(FILTER_LEN - 1)) begin
                filt_d = clk_sync_q[1];
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    // A fall in the same cycle wins over the timeout.
    assign timeout = (state_q != StIdle) && !fall_q && (tcnt_q == TW'(TIMEOUT_CYCLES));

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        parity_d     = parity_q;
        byte_valid_d = 1'b0;
        err          = 1'b0;
        if (timeout) begin
            state_d = StIdle;
            err     = 1'b1;
        end else if (fall_q) begin
            case (state_q)
                StIdle: begin
                    if (!data_bit) begin
                        state_d   = StData;
                        bit_cnt_d = 3'd0;
                    end else begin
                        err = 1'b1;
                    end
                end
                StData: begin
                    shift_d   = {data_bit, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = StParity;
                end
                StParity: begin
                    parity_d = data_bit;
                    state_d  = StStop;
                end
                default: begin
                    if (data_bit && (^{shift_q, parity_q})) byte_valid_d = 1'b1;
                    else err = 1'b1;
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_comb begin
        if (fall_q || timeout || (state_q == StIdle)) tcnt_d = '0;
        else tcnt_d = tcnt_q + 1'b1;
    end

    always_ff @(posedge clk_3m58) begin
        if (reset) begin
            clk_sync_q   <= 2'b11;
            data_sync_q  <= 2'b11;
            filt_q       <= 1'b1;
            filt_prev_q  <= 1'b1;
            fall_q       <= 1'b0;
            fcnt_q       <= '0;
            state_q      <= StIdle;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'd0;
            parity_q     <= 1'b0;
            byte_valid_q <= 1'b0;
            tcnt_q       <= '0;
        end else begin
            clk_sync_q   <= {clk_sync_q[0], ps2_clk_i};
            data_sync_q  <= {data_sync_q[0], ps2_data_i};
            filt_q       <= filt_d;
            filt_prev_q  <= filt_q;
            fall_q       <= filt_prev_q & ~filt_q;
            fcnt_q       <= fcnt_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            byte_valid_q <= byte_valid_d;
            tcnt_q       <= tcnt_d;
        end
    end

    assign byte_o       = shift_q;
    assign byte_valid_o = byte_valid_q;
    assign frame_err_o  = err & ~reset;
    assign busy_o       = (state_q != StIdle);

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard front end: turns received bytes and their E0/F0/E1 prefixes into
// the toggle-flagged 11-bit key event word used by the keypad-matrix logic.
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 716
) (
    input  logic             clk_3m58,
    input  logic             reset,
    input  logic             ps2_clk_i,
    input  logic             ps2_data_i,
    output logic [KEY_W-1:0] ps2_key_o,
    output logic             err_o,
    output logic             busy_o
);

    logic [7:0]       rx_byte;
    logic             byte_valid, frame_err;
    logic [KEY_W-1:0] key_q, key_d;
    logic             ext_q, ext_d, rel_q, rel_d;
    logic [2:0]       skip_q, skip_d;

    ps2_frame_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_frame_rx (
        .clk_3m58     (clk_3m58),
        .reset        (reset),
        .ps2_clk_i    (ps2_clk_i),
        .ps2_data_i   (ps2_data_i),
        .byte_o       (rx_byte),
        .byte_valid_o (byte_valid),
        .frame_err_o  (frame_err),
        .busy_o       (busy_o)
    );

    always_comb begin
        key_d  = key_q;
        ext_d  = ext_q;
        rel_d  = rel_q;
        skip_d = skip_q;
        if (frame_err) begin
            ext_d  = 1'b0;
            rel_d  = 1'b0;
            skip_d = 3'd0;
        end else if (byte_valid) begin
            // Pause is E1 followed by seven bytes that carry no key of their own.
            if (skip_q != 3'd0) begin
                skip_d = skip_q - 3'd1;
            end else if (rx_byte == PS2_EXT) begin
                ext_d = 1'b1;
            end else if (rx_byte == PS2_BRK) begin
                rel_d = 1'b1;
            end else if (rx_byte == PS2_PAUSE) begin
                skip_d = 3'd7;
            end else begin
                if (!is_filler_code(rx_byte)) begin
                    key_d[KEY_TOGGLE]       = ~key_q[KEY_TOGGLE];
                    key_d[KEY_PRESSED]      = ~rel_q;
                    key_d[KEY_EXT]          = ext_q;
                    key_d[KEY_CODE_MSB:0]   = rx_byte;
                end
                ext_d = 1'b0;
                rel_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_3m58) begin
        if (reset) begin
            key_q  <= '0;
            ext_q  <= 1'b0;
            rel_q  <= 1'b0;
            skip_q <= 3'd0;
        end else begin
            key_q  <= key_d;
            ext_q  <= ext_d;
            rel_q  <= rel_d;
            skip_q <= skip_d;
        end
    end

    assign ps2_key_o = key_q;
    assign err_o     = frame_err;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Scoreboard bench for ps2_keyboard_rx: directed PS/2 frames push expected key words,
// a monitor pops and compares on every ps2_key_o change and tallies err_o pulses.
module tb_ps2_keyboard_rx;

    localparam int unsigned FILTER_LEN     = 4;
    localparam int unsigned TIMEOUT_CYCLES = 716;
    localparam int          HALF           = 20;

    logic        clk_3m58 = 1'b0;
    logic        reset    = 1'b1;
    logic        ps2_clk  = 1'b1;
    logic        ps2_data = 1'b1;
    logic [10:0] ps2_key_o;
    logic        err_o, busy_o;

    int          cyc = 0;
    int          fall_cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          err_seen = 0;
    logic [10:0] exp_q[$];

    ps2_keyboard_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk_3m58   (clk_3m58),
        .reset      (reset),
        .ps2_clk_i  (ps2_clk),
        .ps2_data_i (ps2_data),
        .ps2_key_o  (ps2_key_o),
        .err_o      (err_o),
        .busy_o     (busy_o)
    );

    always #5 clk_3m58 = ~clk_3m58;
    always @(posedge clk_3m58) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic v, input bit last);
        @(negedge clk_3m58);
        ps2_data = v;
        repeat (HALF) @(negedge clk_3m58);
        ps2_clk = 1'b0;
        if (last) fall_cyc = cyc;
        repeat (HALF) @(negedge clk_3m58);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i], 1'b0);
        send_bit(~(^b) ^ bad_par, 1'b0);
        send_bit(1'b1, 1'b1);
        repeat (40) @(negedge clk_3m58);
    endtask

    task automatic monitor();
        logic [10:0] prev_key;
        logic        prev_err;
        logic [10:0] exp;
        prev_key = '0;
        prev_err = 1'b0;
        forever begin
            @(negedge clk_3m58);
            if (reset) begin
                prev_key = ps2_key_o;
                prev_err = 1'b0;
            end else begin
                if (err_o) begin
                    err_seen++;
                    chk("err_back_to_back", int'(prev_err), 0);
                end
                prev_err = err_o;
                if (ps2_key_o != prev_key) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_event", int'(ps2_key_o), int'(prev_key));
                    end else begin
                        exp = exp_q.pop_front();
                        chk("key_event", int'(ps2_key_o), int'(exp));
                        chk("key_latency", cyc - fall_cyc, int'(FILTER_LEN) + 5);
                    end
                    prev_key = ps2_key_o;
                end
            end
        end
    endtask

    initial begin
        int  e0;
        bit  busy_any;
        fork
            monitor();
        join_none

        repeat (5) @(negedge clk_3m58);
        reset = 1'b0;
        @(negedge clk_3m58);
        chk("reset_key", int'(ps2_key_o), 0);
        chk("reset_err", int'(err_o), 0);
        chk("reset_busy", int'(busy_o), 0);

        // Plain make code.
        exp_q.push_back(11'h61C);
        send_frame(8'h1C, 1'b0);
        chk("make_1c_no_err", err_seen, 0);

        // Break code.
        exp_q.push_back(11'h01C);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b0);

        // Extended make then extended break.
        exp_q.push_back(11'h775);
        send_frame(8'hE0, 1'b0);
        send_frame(8'h75, 1'b0);
        exp_q.push_back(11'h175);
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h75, 1'b0);
        chk("ext_no_err", err_seen, 0);

        // Bad parity clears the pending release prefix.
        e0 = err_seen;
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b1);
        chk("parity_err_count", err_seen - e0, 1);
        chk("parity_no_event", exp_q.size(), 0);
        exp_q.push_back(11'h61C);
        send_frame(8'h1C, 1'b0);

        // Truncated frame: start plus four data bits, then silence.
        e0 = err_seen;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
        @(negedge clk_3m58);
        chk("partial_busy", int'(busy_o), 1);
        repeat (TIMEOUT_CYCLES + 10) @(negedge clk_3m58);
        chk("timeout_err_count", err_seen - e0, 1);
        chk("timeout_busy_drop", int'(busy_o), 0);
        exp_q.push_back(11'h21C);
        send_frame(8'h1C, 1'b0);

        // Pause sequence produces nothing.
        e0 = err_seen;
        send_frame(8'hE1, 1'b0);
        send_frame(8'h14, 1'b0);
        send_frame(8'h77, 1'b0);
        send_frame(8'hE1, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h14, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h77, 1'b0);

        // Short low glitch on the clock pin while idle.
        busy_any = 1'b0;
        @(negedge clk_3m58);
        ps2_clk = 1'b0;
        repeat (2) @(negedge clk_3m58);
        ps2_clk = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk_3m58);
            busy_any |= busy_o;
        end
        chk("glitch_busy", int'(busy_any), 0);
        chk("pause_glitch_no_err", err_seen - e0, 0);
        chk("pause_key_unchanged", int'(ps2_key_o), 11'h21C);

        repeat (20) @(negedge clk_3m58);
        chk("pending_events", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_keyboard_rx.md
# ps2_keyboard_rx

- Receives a raw PS/2 keyboard stream on the clock and data pins.
- Decodes scan-code sets with their E0/F0/E1 prefixes into the 11-bit `ps2_key` event word that the console's keypad-matrix logic consumes.
- Sits between the board PS/2 pins and the MyVision top, so the core no longer depends on a framework-supplied key word.
- Runs entirely on the CPU clock domain.

## Interface
Parameters:
- FILTER_LEN, 4: consecutive identical clk_3m58 samples required before the filtered PS/2 clock changes level.
- TIMEOUT_CYCLES, 716: idle cycles (~200 µs) allowed between PS/2 clock falling edges inside a frame before the frame is abandoned.

Ports:
- clk_3m58  in  1  system clock, 3.58 MHz.
- reset  in  1  reset, synchronous, active-high.
- ps2_clk_i  in  1  raw PS/2 clock pin, asynchronous.
- ps2_data_i  in  1  raw PS/2 data pin, asynchronous.
- ps2_key_o  out  11  [10] toggles once per key event, [9] pressed, [8] extended (E0), [7:0] scan code.
- err_o  out  1  one-cycle pulse on a parity, start/stop or timeout error.
- busy_o  out  1  high while a frame is in progress.

## Operation
- **Input conditioning**
  - Both pins pass through a 2-FF synchronizer.
  - Synced clock goes through a FILTER_LEN glitch filter; filtered level resets to 1.
  - A falling edge of the filtered clock produces a one-cycle `fall` strobe.
  - Data is the synced value sampled on the `fall` cycle.
- **Frame FSM** (states IDLE, DATA, PARITY, STOP):
  - IDLE: on `fall` with data=0 go to DATA with bit count 0. On `fall` with data=1, stay in IDLE and pulse err_o.
  - DATA: shift data in LSB first. After the 8th bit go to PARITY.
  - PARITY: latch the bit. The eight data bits plus parity must contain an odd number of ones.
  - STOP: on `fall`, if stop=1 and parity is good, emit the byte as a one-cycle `byte_valid`. Otherwise pulse err_o. Return to IDLE in either case.
  - busy_o = (state != IDLE).
- **Timeout**
  - The counter clears on every `fall` and counts while the state is not IDLE.
  - When the count reaches TIMEOUT_CYCLES: go to IDLE, pulse err_o, discard partial bits.
- **Prefix decoder** (acts on `byte_valid`):
  - E0: set ext.
  - F0: set rel.
  - E1: set skip = 7. While skip > 0, each byte decrements skip and is dropped; no event is generated.
  - FA, AA, EE, FE, 00, FF: drop the byte and clear ext and rel.
  - Any other byte: ps2_key_o <= {~ps2_key_o[10], ~rel, ext, byte}, then clear ext and rel.
- Any err_o pulse also clears ext, rel and skip, so a stale prefix never applies to the next code.

## Timing
- **Reset values:** ps2_key_o = 0, err_o = 0, busy_o = 0, state IDLE, ext/rel/skip = 0, filtered clock = 1, timeout counter = 0.
- **Reset mid-frame** abandons the frame silently; no err_o pulse.
- **Pipeline latency:**
  - Pin falling edge to `fall`: 2 sync + FILTER_LEN filter + 1 edge register.
  - `byte_valid` is registered 1 cycle after the stop-bit `fall`.
  - ps2_key_o updates 1 cycle after `byte_valid`.
  - Total: 11th pin falling edge to ps2_key_o change = FILTER_LEN + 5 cycles.
- **Event rate:** ps2_key_o changes at most once per frame. Bit 10 flips exactly once per emitted event, and bits [9:0] change in the same cycle as bit 10.
- **err_o** is asserted in the cycle the fault is detected: the stop-bit `fall` cycle, the start-bit `fall` cycle, or the cycle the timeout count reaches TIMEOUT_CYCLES. It is never high for two consecutive cycles.
- **Simultaneous events:** a timeout and a `fall` in the same cycle are resolved in favour of `fall`, which also clears the counter.
- **Glitch rejection:** pulses shorter than FILTER_LEN cycles on ps2_clk_i produce no `fall`.

## Structure
- Shared package `ps2_pkg`:
  - byte constants PS2_EXT (E0), PS2_BRK (F0), PS2_PAUSE (E1), PS2_ACK (FA), PS2_BAT (AA), PS2_ECHO (EE), PS2_RESEND (FE);
  - the frame-state enum;
  - the ps2_key bit-field index constants.
- Sub-module `ps2_frame_rx`: synchronizer, filter, frame FSM and timeout. Outputs byte, byte_valid, frame_err and busy.
- The top level holds the prefix decoder and the output register.

## Test plan
- Frame 1C with good parity → ps2_key_o = {1, 1, 0, 8'h1C}, i.e. 11'h61C, after FILTER_LEN + 5 cycles; err_o stays 0.
- Frames F0, 1C following the previous test → ps2_key_o = 11'h01C (bit10 = 0, pressed = 0); bit10 flips exactly once.
- Frames E0, 75 → ps2_key_o[9:8] = 2'b11 and [7:0] = 8'h75. Then E0, F0, 75 → [9:8] = 2'b01.
- F0, then 1C with a bad parity bit, then 1C good:
  - err_o pulses once, with no event from the bad frame;
  - the final 1C gives pressed = 1, proving rel was cleared.
- Five bits sent, then the clock held high for TIMEOUT_CYCLES + 10 → err_o pulses once, busy_o drops, and a following 1C frame decodes normally.
- Pause sequence E1 14 77 E1 F0 14 F0 77, plus a 2-cycle low glitch on ps2_clk_i while idle → no ps2_key_o change, no err_o, busy_o stays 0 through the glitch.
